// File: rtl/vq_pkg.sv
// rtl/vq_pkg.sv - shared widths, codebook layout and FSM state type for the VQ decompressor
// Purpose: constants and types imported by the interface, register file and top.
// Ports: none (package).
package vq_pkg;

  localparam int PIX_W    = 24;  // RGB 8:8:8 pixel / codebook word
  localparam int IDX_W    = 3;   // codebook index width
  localparam int CB_DEPTH = 8;   // 2**IDX_W codebook entries
  localparam int CB_BASE  = 0;   // RAM2 address of codebook entry 0
  localparam int IDX_BASE = 8;   // RAM2 address of the first pixel index

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DECODE,
    DRAIN,
    DONE
  } vq_state_e;

endpackage

// File: rtl/vq_decompressor_if.sv
// rtl/vq_decompressor_if.sv - control and RAM2/RAM3 port bundle of the VQ decompressor
// Purpose: groups the start/busy/done handshake, the RAM2 read port and the RAM3 write port.
// Ports (signals): start, busy, done; ram2_re, ram2_a, ram2_q; ram3_we, ram3_a, ram3_d.
// Modports: master = decompressor side, slave = controller/memory side.
interface vq_decompressor_if #(
  parameter int ADDR_W = 20
);
  import vq_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              ram2_re;
  logic [ADDR_W-1:0] ram2_a;
  logic [PIX_W-1:0]  ram2_q;
  logic              ram3_we;
  logic [ADDR_W-1:0] ram3_a;
  logic [PIX_W-1:0]  ram3_d;

  modport master (
    input  start, ram2_q,
    output busy, done, ram2_re, ram2_a, ram3_we, ram3_a, ram3_d
  );

  modport slave (
    output start, ram2_q,
    input  busy, done, ram2_re, ram2_a, ram3_we, ram3_a, ram3_d
  );

endinterface

// File: rtl/vq_codebook_rf.sv
// rtl/vq_codebook_rf.sv - 8x24 codebook register file
// Purpose: holds the RGB codebook; one synchronous write port, one combinational read port.
// Ports: clk, rst (async, active-high clear of all entries);
//        we/waddr/wdata write port; raddr/rdata combinational read port.
module vq_codebook_rf
  import vq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] cb_q [CB_DEPTH];
  logic [PIX_W-1:0] cb_d [CB_DEPTH];

  always_comb begin
    for (int i = 0; i < CB_DEPTH; i++) begin
      cb_d[i] = cb_q[i];
    end
    if (we) begin
      cb_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CB_DEPTH; i++) begin
        cb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CB_DEPTH; i++) begin
        cb_q[i] <= cb_d[i];
      end
    end
  end

  assign rdata = cb_q[raddr];

endmodule

// File: rtl/vq_decompressor.sv
// rtl/vq_decompressor.sv - codebook VQ decompressor: RAM2 (codebook + indices) -> RAM3 pixels
// Purpose: on start, loads 8 codebook words from RAM2[0..7], then streams indices from
//          RAM2[8..] and writes cb[index] for each pixel to RAM3.
// Ports: clk, rst (async, active-high);
//        bus (vq_decompressor_if.master): start/busy/done, RAM2 read port, RAM3 write port.
module vq_decompressor
  import vq_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int NUM_PIX = 16384
) (
  input logic                clk,
  input logic                rst,
  vq_decompressor_if.master  bus
);

  localparam logic [ADDR_W-1:0] CB_FIRST  = ADDR_W'(CB_BASE);
  localparam logic [ADDR_W-1:0] CB_LAST   = ADDR_W'(IDX_BASE - 1);
  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(IDX_BASE);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(IDX_BASE + NUM_PIX - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(NUM_PIX - 1);

  vq_state_e state_q, state_d;

  logic              ram2_re_q, ram2_re_d;
  logic [ADDR_W-1:0] ram2_a_q, ram2_a_d;
  // Tags for the RAM2 word arriving this cycle (issued one cycle earlier).
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              ram3_we_q, ram3_we_d;
  logic [ADDR_W-1:0] ram3_a_q, ram3_a_d;
  logic [PIX_W-1:0]  ram3_d_q, ram3_d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cb_we;
  logic              pix_valid;
  logic [PIX_W-1:0]  cb_rdata;

  assign cb_we     = rsp_valid_q && (rsp_addr_q < IDX_FIRST);
  assign pix_valid = rsp_valid_q && (rsp_addr_q >= IDX_FIRST);

  // cb[7] lands at the end of the cycle address 8 is issued, one cycle
  // before the first index returns, so lookups never see a stale entry.
  vq_codebook_rf u_cb (
    .clk   (clk),
    .rst   (rst),
    .we    (cb_we),
    .waddr (rsp_addr_q[IDX_W-1:0]),
    .wdata (bus.ram2_q),
    .raddr (bus.ram2_q[IDX_W-1:0]),
    .rdata (cb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (ram2_a_q == CB_LAST) state_d = DECODE;
      DECODE:  if (ram2_a_q == IDX_LAST) state_d = DRAIN;
      DRAIN:   if (ram3_we_q && (ram3_a_q == PIX_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so everything here is derived from state_d.
  always_comb begin
    ram2_re_d   = (state_d == LOAD) || (state_d == DECODE);
    ram2_a_d    = ram2_a_q;
    if ((state_q == IDLE) && (state_d == LOAD)) begin
      ram2_a_d = CB_FIRST;
    end else if (ram2_re_d) begin
      ram2_a_d = ram2_a_q + 1'b1;
    end
    rsp_valid_d = ram2_re_q;
    rsp_addr_d  = ram2_a_q;
    ram3_we_d   = pix_valid;
    ram3_a_d    = pix_valid ? (rsp_addr_q - IDX_FIRST) : ram3_a_q;
    ram3_d_d    = pix_valid ? cb_rdata : ram3_d_q;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram2_re_q   <= 1'b0;
      ram2_a_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      ram3_we_q   <= 1'b0;
      ram3_a_q    <= '0;
      ram3_d_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ram2_re_q   <= ram2_re_d;
      ram2_a_q    <= ram2_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      ram3_we_q   <= ram3_we_d;
      ram3_a_q    <= ram3_a_d;
      ram3_d_q    <= ram3_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ram2_re = ram2_re_q;
  assign bus.ram2_a  = ram2_a_q;
  assign bus.ram3_we = ram3_we_q;
  assign bus.ram3_a  = ram3_a_q;
  assign bus.ram3_d  = ram3_d_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/vq_decompressor.md
Name: vq_decompressor

Overview:
Decompress-side engine of the codebook image path: the inverse of the compress pipeline. On a start pulse it loads an 8-entry 24-bit RGB codebook from the compressed memory (RAM2), then streams 3-bit indices from RAM2. It writes the reconstructed pixel for each index to the output image memory (RAM3). It sits between the RAM2 read port and the RAM3 write port, and runs under a top-level controller via start/busy/done.

Parameters:
ADDR_W, 20, address width of RAM2 and RAM3
PIX_W, 24, pixel/codebook word width (RGB 8:8:8)
IDX_W, 3, codebook index width; codebook depth = 2**IDX_W = 8
NUM_PIX, 16384, pixels per image, 1..2**ADDR_W-8

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
start  in  1  one-cycle request, sampled only in IDLE
ram2_q  in  PIX_W  RAM2 read data, synchronous read, 1-cycle latency
ram2_re  out  1  RAM2 read enable
ram2_a  out  ADDR_W  RAM2 read address
ram3_we  out  1  RAM3 write enable
ram3_a  out  ADDR_W  RAM3 write address (pixel number)
ram3_d  out  PIX_W  RAM3 write data (reconstructed pixel)
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse at end of image

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset drives state=IDLE, clears all outputs and counters to 0, and clears all 8 codebook entries to 0. Reset mid-operation aborts immediately; no further RAM writes occur, and a new start is required.
- All outputs are registered.
- RAM2 layout: addresses 0..7 hold codebook entries 0..7. Addresses 8..8+NUM_PIX-1 hold one index per word in ram2_q[IDX_W-1:0]; upper bits are ignored.
- FSM states: IDLE, LOAD, DECODE, DRAIN, DONE.
- IDLE: on start=1, go to LOAD with rd_addr=0. start is ignored in all other states.
- LOAD: ram2_re=1 and ram2_a=rd_addr each cycle; rd_addr increments. After address 7 is issued, go to DECODE with address 8 issued next cycle, with no bubble.
- Codebook capture: data for address k (k<8) arrives the cycle after issue and is written to cb[k].
- DECODE: issues addresses 8..8+NUM_PIX-1 back-to-back. After the last address is issued, go to DRAIN with ram2_re=0.
- Write pipeline: index data returns in cycle t+1. In cycle t+2, ram3_we=1, ram3_a=i and ram3_d=cb[idx], where i = address-8.
  - cb[7] is captured in the same cycle address 8 is issued, so it is always valid before the first lookup.
- DRAIN: hold until the write for pixel NUM_PIX-1 is presented, then go to DONE.
- DONE: done=1 for exactly one cycle; busy is still 1; next state is IDLE.
- Timing: take cycle 0 as the cycle start is sampled; cycle n follows the n-th rising edge after it.
  - Address a is on ram2_a in cycle a+1.
  - Pixel i is written in cycle i+11.
  - done is high in cycle NUM_PIX+11; busy is high in cycles 1..NUM_PIX+11.
- ram3_we is low in every cycle without a valid pixel. ram3_a and ram3_d hold their last values when ram3_we is low.
- Width rules: pixel counter is ADDR_W bits, with no wrap within an image. RAM2 address = pixel+8, computed in ADDR_W bits.
- Codebook persists after DONE until the next LOAD or reset.

Decomposition:
- Package vq_pkg holds: PIX_W, IDX_W, CB_DEPTH=8, CB_BASE=0, IDX_BASE=8, and the state enum (IDLE, LOAD, DECODE, DRAIN, DONE).
- Sub-module vq_codebook_rf: 8x24 register file with one synchronous write port, one combinational read port, and asynchronous clear on rst.
- FSM, address counter and write pipeline live in the top.

Test Plan:
- Reset: assert rst mid-sim -> all outputs 0 and busy 0; subsequent reads of the codebook via decode return 24'h000000.
- Basic image: NUM_PIX=4; RAM2[0..7]=24'h000000,24'h111111,...,24'h777777; indices 3,0,7,5 -> writes (0,333333),(1,000000),(2,777777),(3,555555) in cycles 11..14; done only in cycle 15; busy cycles 1..15.
- Upper-bit masking: index word 24'hFFFFF9 -> pixel = cb[1] = 24'h111111.
- Start while busy: pulse start during DECODE -> no restart; address sequence and write count are unchanged (exactly 4 writes).
- Mid-run reset: assert rst in cycle 12 -> ram3_we=0 immediately; no write in cycle 13+; after release, start begins at address 0.
- Back-to-back images: start again in the cycle after done with a new codebook -> second image uses the new entries and done pulses again at cycle NUM_PIX+11 relative to the second start.
